serv_boot_sequencer: RTL and testbench

Boot controller for the SERV core-RAM AXI slave port. It holds the core in reset and accepts program words from a host-side valid/ready stream. Each word is written to core RAM through single-beat AXI4 writes at incrementing addresses. After the last write response is OKAY, the sequencer releases core reset. It sits between the SoC host/loader and the core block's AXI slave write channels and its rst input.

---
 rtl/serv_boot_pkg.sv | 18 +
 rtl/serv_boot_sequencer.sv | 161 ++++++++++++++++
 tb/tb_serv_boot_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_boot_pkg.sv
// Shared types and constants for the SERV boot sequencer.
// No timing or flow-control behaviour of its own.
package serv_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    RESP,
    RUN,
    ERR
  } state_t;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [3:0]  WSTRB_FULL    = 4'hF;
  localparam int unsigned WORD_BYTES    = 4;

endpackage

// File: rtl/serv_boot_sequencer.sv
// Loads host words into core RAM via single-beat AXI writes, then releases core reset.
// 3 cycles/word minimum; host stalled by o_ready, AW/W/B each wait on their own handshake.
module serv_boot_sequencer
  import serv_boot_pkg::*;
#(
  parameter int AW        = 13,
  parameter int MEMSIZE   = 8192,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_len,
  input  logic [31:0]   i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic          o_core_rst,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [AW-1:0] o_awaddr,
  output logic          o_awvalid,
  input  logic          i_awready,
  output logic [31:0]   o_wdata,
  output logic [3:0]    o_wstrb,
  output logic          o_wvalid,
  input  logic          i_wready,
  input  logic [1:0]    i_bresp,
  input  logic          i_bvalid,
  output logic          o_bready
);

  localparam int unsigned   MAX_WORDS = MEMSIZE / WORD_BYTES;
  localparam logic [AW-1:0] BASE      = AW'(BASE_ADDR);
  localparam logic [AW-1:0] STRIDE    = AW'(WORD_BYTES);

  state_t        state, state_nxt;
  logic [AW-1:0] len_q;
  logic [AW-1:0] idx;
  logic          aw_done, w_done;
  logic          aw_hs, w_hs;
  logic          aw_ok, w_ok;
  logic          len_bad;
  logic          last_word;

  assign aw_hs     = o_awvalid & i_awready;
  assign w_hs      = o_wvalid & i_wready;
  // A channel counts as finished either from an earlier handshake or one happening now.
  assign aw_ok     = aw_done | aw_hs;
  assign w_ok      = w_done | w_hs;
  assign len_bad   = 32'(i_len) > MAX_WORDS;
  assign last_word = (idx == len_q - AW'(1));
  assign o_wstrb   = WSTRB_FULL;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN, ERR: begin
        if (i_start) begin
          if (len_bad) begin
            state_nxt = ERR;
          end else if (i_len == '0) begin
            state_nxt = RUN;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        if (i_valid) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (aw_ok && w_ok) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (i_bvalid) begin
          if (i_bresp != AXI_RESP_OKAY) begin
            state_nxt = ERR;
          end else if (last_word) begin
            state_nxt = RUN;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready    = (state == FETCH);
    o_bready   = (state == RESP);
    o_busy     = (state == FETCH) || (state == WRITE) || (state == RESP);
    o_done     = (state == RUN);
    o_err      = (state == ERR);
    o_core_rst = (state != RUN);
  end

  // Payload is captured once per word in FETCH and held until the next accept,
  // so AW/W contents stay stable for as long as either valid is up.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      idx       <= '0;
      o_awaddr  <= BASE;
      o_wdata   <= '0;
      o_awvalid <= 1'b0;
      o_wvalid  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (i_start) begin
            len_q <= i_len;
            idx   <= '0;
          end
        end
        FETCH: begin
          if (i_valid) begin
            o_wdata   <= i_data;
            o_awaddr  <= BASE + idx * STRIDE;
            o_awvalid <= 1'b1;
            o_wvalid  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
          end
        end
        WRITE: begin
          if (aw_hs) begin
            o_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            o_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
        end
        RESP: begin
          if (i_bvalid && (i_bresp == AXI_RESP_OKAY) && !last_word) begin
            idx <= idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_boot_sequencer.sv
// Directed plus randomized bench for serv_boot_sequencer with host/slave models and
// an arithmetic reference of which writes a load must produce and how it must end.
module tb_serv_boot_sequencer;

  localparam int AW        = 13;
  localparam int MEMSIZE   = 8192;
  localparam int BASE_ADDR = 0;
  localparam int MAXW      = MEMSIZE / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_len = '0;
  logic [31:0]   i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready, o_core_rst, o_busy, o_done, o_err;
  logic [AW-1:0] o_awaddr;
  logic          o_awvalid;
  logic          i_awready = 1'b0;
  logic [31:0]   o_wdata;
  logic [3:0]    o_wstrb;
  logic          o_wvalid;
  logic          i_wready = 1'b0;
  logic [1:0]    i_bresp = 2'b00;
  logic          i_bvalid = 1'b0;
  logic          o_bready;

  always #5 clk = ~clk;

  serv_boot_sequencer #(.AW(AW), .MEMSIZE(MEMSIZE), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .o_core_rst(o_core_rst), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_awaddr(o_awaddr), .o_awvalid(o_awvalid),
    .i_awready(i_awready), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid),
    .i_wready(i_wready), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host: offers words from host_mem[host_rd .. host_wr-1] whenever the DUT is ready.
  logic [31:0] host_mem [0:8191];
  int          acc_cyc  [0:8191];
  int          host_rd = 0;
  int          host_wr = 0;
  bit          rand_mode = 1'b0;

  always @(negedge clk) begin
    if (o_ready && (host_rd < host_wr) && (!rand_mode || $urandom_range(0, 3) != 0)) begin
      i_valid = 1'b1;
      i_data  = host_mem[host_rd];
      acc_cyc[host_rd] = cyc;
      host_rd++;
    end else begin
      i_valid = 1'b0;
      i_data  = $urandom;
    end
  end

  // Slave: per-channel delays, records handshakes, checks payload stability and ordering.
  int            fix_aw = 0, fix_w = 0, fix_b = 0, err_word = -1;
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int            aw_dly = 0, w_dly = 0, b_dly = 0;
  int            b_index = 0, outstanding = 0, done_cnt = 0;
  bit            aw_hold = 1'b0, w_hold = 1'b0;
  logic [AW-1:0] aw_prev = '0;
  logic [31:0]   w_prev = '0;
  logic [AW-1:0] got_aw [$];
  logic [31:0]   got_w  [$];

  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_busy) chk("core_rst_held_busy", 32'(o_core_rst), 1);
    if (!o_busy) begin
      b_index     = 0;
      outstanding = 0;
    end
    if (o_awvalid) begin
      if (aw_hold) chk("aw_stable", 32'(o_awaddr), 32'(aw_prev));
      i_awready = (aw_cnt >= aw_dly);
      aw_cnt++;
      aw_hold = !i_awready;
      aw_prev = o_awaddr;
      if (i_awready) begin
        chk("aw_one_outstanding", outstanding, 0);
        got_aw.push_back(o_awaddr);
        outstanding++;
      end
    end else begin
      i_awready = 1'b0;
      aw_cnt    = 0;
      aw_hold   = 1'b0;
      aw_dly    = rand_mode ? int'($urandom_range(0, 3)) : fix_aw;
    end
    if (o_wvalid) begin
      if (w_hold) chk("w_stable", o_wdata, w_prev);
      i_wready = (w_cnt >= w_dly);
      w_cnt++;
      w_hold = !i_wready;
      w_prev = o_wdata;
      if (i_wready) begin
        chk("wstrb", 32'(o_wstrb), 32'hF);
        got_w.push_back(o_wdata);
      end
    end else begin
      i_wready = 1'b0;
      w_cnt    = 0;
      w_hold   = 1'b0;
      w_dly    = rand_mode ? int'($urandom_range(0, 4)) : fix_w;
    end
    if (o_bready) begin
      i_bvalid = (b_cnt >= b_dly);
      b_cnt++;
      i_bresp = (b_index == err_word) ? 2'b10 : 2'b00;
      if (i_bvalid) begin
        b_index++;
        outstanding--;
      end
    end else begin
      i_bvalid = 1'b0;
      i_bresp  = 2'b00;
      b_cnt    = 0;
      b_dly    = rand_mode ? int'($urandom_range(0, 3)) : fix_b;
    end
  end

  int hbase = 0, aw_base = 0, w_base = 0, end_cyc = 0, d0 = 0;

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) host_mem[host_rd + k] = $urandom;
  endtask

  task automatic pulse_start(input int len);
    hbase   = host_rd;
    host_wr = host_rd + ((len <= MAXW) ? len : 0);
    aw_base = got_aw.size();
    w_base  = got_w.size();
    @(negedge clk);
    i_start = 1'b1;
    i_len   = AW'(len);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Reference: a load writes words 0..n-1 at BASE+4k, stopping after a bad response.
  task automatic finish_load(input int len, input string tag);
    int            nw;
    bit            exp_err;
    bit            to;
    logic [AW-1:0] ea;
    to = 1'b1;
    for (int c = 0; c < 20 * len + 100; c++) begin
      if (!o_busy) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    end_cyc = cyc;
    chk({tag, "_timeout"}, 32'(to), 0);
    if (len > MAXW) begin
      nw = 0; exp_err = 1'b1;
    end else if (err_word >= 0 && err_word < len) begin
      nw = err_word + 1; exp_err = 1'b1;
    end else begin
      nw = len; exp_err = 1'b0;
    end
    chk({tag, "_aw_count"}, got_aw.size() - aw_base, nw);
    chk({tag, "_w_count"}, got_w.size() - w_base, nw);
    for (int k = 0; k < nw; k++) begin
      ea = AW'(BASE_ADDR + 4 * k);
      if (aw_base + k < got_aw.size()) chk({tag, "_awaddr"}, 32'(got_aw[aw_base + k]), 32'(ea));
      if (w_base + k < got_w.size()) chk({tag, "_wdata"}, got_w[w_base + k], host_mem[hbase + k]);
    end
    chk({tag, "_done"}, 32'(o_done), 32'(!exp_err));
    chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
    chk({tag, "_core_rst"}, 32'(o_core_rst), 32'(exp_err));
    chk({tag, "_ready"}, 32'(o_ready), 0);
    chk({tag, "_awvalid"}, 32'(o_awvalid), 0);
    chk({tag, "_wvalid"}, 32'(o_wvalid), 0);
    chk({tag, "_bready"}, 32'(o_bready), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_core_rst"}, 32'(o_core_rst), 1);
    chk({tag, "_ready"}, 32'(o_ready), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
    chk({tag, "_awvalid"}, 32'(o_awvalid), 0);
    chk({tag, "_wvalid"}, 32'(o_wvalid), 0);
    chk({tag, "_bready"}, 32'(o_bready), 0);
    chk({tag, "_awaddr"}, 32'(o_awaddr), 32'(BASE_ADDR));
    chk({tag, "_wdata"}, o_wdata, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_wstrb", 32'(o_wstrb), 32'hF);
    rst = 1'b0;

    // Zero-wait three-word load and its end-to-end latency.
    host_mem[host_rd]     = 32'hDEADBEEF;
    host_mem[host_rd + 1] = 32'h01234567;
    host_mem[host_rd + 2] = 32'hCAFEF00D;
    pulse_start(3);
    finish_load(3, "zw3");
    chk("zw3_cycles", end_cyc - acc_cyc[hbase], 9);

    // Late slave on every channel.
    fix_aw = 2; fix_w = 4; fix_b = 3;
    fill_random(2);
    pulse_start(2);
    finish_load(2, "stall");
    fix_aw = 0; fix_w = 0; fix_b = 0;

    // Oversize length goes straight to ERR; zero length straight to RUN.
    pulse_start(MAXW + 1);
    chk("big_err_1cyc", 32'(o_err), 1);
    chk("big_core_rst_1cyc", 32'(o_core_rst), 1);
    finish_load(MAXW + 1, "big");
    pulse_start(0);
    chk("zero_done_1cyc", 32'(o_done), 1);
    chk("zero_core_rst_1cyc", 32'(o_core_rst), 0);
    finish_load(0, "zero");

    // Second response is SLVERR, then a clean single-word reload.
    err_word = 1;
    fill_random(3);
    pulse_start(3);
    d0 = done_cnt;
    finish_load(3, "bresp");
    chk("bresp_no_done", done_cnt - d0, 0);
    err_word = -1;
    fill_random(1);
    pulse_start(1);
    finish_load(1, "after_err");

    // Reset while AW is pending.
    fix_aw = 10; fix_w = 10;
    fill_random(2);
    pulse_start(2);
    for (int c = 0; c < 20; c++) begin
      if (o_awvalid) break;
      @(negedge clk);
    end
    chk("rst_aw_seen", 32'(o_awvalid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    fix_aw = 0; fix_w = 0;
    fill_random(1);
    pulse_start(1);
    finish_load(1, "post_rst");

    // Start pulse during a load must be ignored.
    fix_b = 3;
    fill_random(2);
    pulse_start(2);
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_stray", 32'(o_busy), 1);
    i_start = 1'b1;
    i_len   = '0;
    @(negedge clk);
    i_start = 1'b0;
    finish_load(2, "busy_ign");
    fix_b = 0;

    // Reload from RUN re-asserts core reset immediately.
    fill_random(1);
    pulse_start(1);
    chk("rerun_core_rst", 32'(o_core_rst), 1);
    finish_load(1, "rerun");

    // Largest legal load fills RAM exactly.
    fill_random(MAXW);
    pulse_start(MAXW);
    finish_load(MAXW, "full");

    // Randomized lengths, data, delays and error positions.
    rand_mode = 1'b1;
    for (int t = 0; t < 8; t++) begin
      int len;
      len      = int'($urandom_range(1, 6));
      err_word = int'($urandom_range(0, 9));
      fill_random(len);
      pulse_start(len);
      finish_load(len, "rand");
    end
    rand_mode = 1'b0;
    err_word  = -1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
